present80_round_engine: RTL and testbench

//  Iterative PRESENT-80 encryption core: one cipher round per clock.

---
 rtl/present80_round_engine_if.sv | 18 +
 rtl/present80_round_engine.sv | 64 ++++++
 tb/tb_present80_round_engine.sv | 101 ++++++++++
 3 files changed

// File: rtl/present80_round_engine_if.sv
// present80_round_engine_if: start/done handshake and data bus of the PRESENT-80 core (PRESENT_DBG_EN adds debug taps)
interface present80_round_engine_if;
  logic start;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic busy;
  logic done;
  logic [63:0] ciphertext;
`ifdef PRESENT_DBG_EN
  logic [4:0] dbg_round;
  logic [63:0] dbg_state;
  modport master(output start, plaintext, key, input busy, done, ciphertext, dbg_round, dbg_state);
  modport slave(input start, plaintext, key, output busy, done, ciphertext, dbg_round, dbg_state);
`else
  modport master(output start, plaintext, key, input busy, done, ciphertext);
  modport slave(input start, plaintext, key, output busy, done, ciphertext);
`endif
endinterface

// File: rtl/present80_round_engine.sv
// present80_round_engine: iterative PRESENT-80 encryption, one round per clock; PRESENT_DBG_EN adds dbg_round/dbg_state
module present80_round_engine #(
  parameter int ROUNDS = 31
) (
  input logic clk,
  input logic reset,
  present80_round_engine_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2;
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
  logic [1:0] fsm;
  logic [4:0] round_cnt;
  logic [63:0] state, ct, sb, pl;
  logic [79:0] keyreg, kr, kn;
  logic busy, done;
  function automatic logic [3:0] s(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction
  always_comb begin
    sb = '0;
    pl = '0;
    for (int i = 0; i < 16; i++) sb[4*i +: 4] = s(state[4*i +: 4] ^ keyreg[16+4*i +: 4]);
    for (int i = 0; i < 64; i++) pl[i == 63 ? 63 : (16*i) % 63] = sb[i];
    kr = {keyreg[18:0], keyreg[79:19]};
    kn = {s(kr[79:76]), kr[75:20], kr[19:15] ^ round_cnt, kr[14:0]};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm <= IDLE;
      round_cnt <= '0;
      state <= '0;
      keyreg <= '0;
      ct <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fsm == IDLE && bus.start) begin
        state <= bus.plaintext;
        keyreg <= bus.key;
        round_cnt <= 5'd1;
        busy <= 1'b1;
        fsm <= ROUND;
      end else if (fsm == ROUND) begin
        state <= pl;
        keyreg <= kn;
        if (round_cnt == 5'(ROUNDS)) fsm <= FINAL;
        else round_cnt <= round_cnt + 5'd1;
      end else if (fsm == FINAL) begin
        ct <= state ^ keyreg[79:16];
        done <= 1'b1;
        busy <= 1'b0;
        fsm <= IDLE;
      end
    end
  end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.ciphertext = ct;
`ifdef PRESENT_DBG_EN
  assign bus.dbg_round = round_cnt;
  assign bus.dbg_state = state;
`endif
endmodule

// File: tb/tb_present80_round_engine.sv
// tb_present80_round_engine: scoreboard bench for present80_round_engine using known PRESENT-80 vectors
module tb_present80_round_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [63:0] sb_q[$];
  present80_round_engine_if bus();
  present80_round_engine dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (reset && bus.done) begin
      if (sb_q.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else check("ciphertext", bus.ciphertext, sb_q.pop_front());
    end
  task automatic launch(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp);
    bus.start = 1'b1;
    bus.plaintext = pt;
    bus.key = k;
    sb_q.push_back(exp);
    @(negedge clk);
    t_acc = cyc;
    bus.start = 1'b0;
    bus.plaintext = {$urandom, $urandom};
    bus.key = {$urandom, $urandom, $urandom};
    check("busy_accept", 64'(bus.busy), 64'd1);
  endtask
  task automatic wait_done();
    while (!bus.done && cyc - t_acc < 40) @(negedge clk);
    check("latency", 64'(cyc - t_acc), 64'd32);
  endtask
  task automatic finish_run();
    wait_done();
    @(negedge clk);
    check("done_drop", 64'(bus.done), 64'd0);
    check("busy_idle", 64'(bus.busy), 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.plaintext = '0;
    bus.key = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ct", bus.ciphertext, 64'd0);
`ifdef PRESENT_DBG_EN
    check("rst_dbg_round", 64'(bus.dbg_round), 64'd0);
    check("rst_dbg_state", bus.dbg_state, 64'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    launch(64'h0, 80'h0, 64'h5579C1387B228445);
`ifdef PRESENT_DBG_EN
    check("dbg_round_first", 64'(bus.dbg_round), 64'd1);
`endif
    finish_run();
    launch(64'h0, '1, 64'hE72C46C0F5945049);
    finish_run();
    launch('1, 80'h0, 64'hA112FFC72F68417B);
    finish_run();
    launch('1, '1, 64'h3333DCD3213210D2);
    finish_run();
    launch(64'h0, 80'h0, 64'h5579C1387B228445);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.key = '1;
    bus.plaintext = '1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_run();
    repeat (40) @(negedge clk);
    launch(64'h0, 80'h0, 64'h5579C1387B228445);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ct", bus.ciphertext, 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    launch(64'h0, 80'h0, 64'h5579C1387B228445);
    wait_done();
    launch(64'h0, '1, 64'hE72C46C0F5945049);
    check("b2b_done_drop", 64'(bus.done), 64'd0);
    finish_run();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
